value_rank: RTL and testbench

- Inverse of the nth-smallest selector: that block maps index -> value; this block maps value -> rank.
- Holds a buffer of NUM_OF_NUMS unsigned numbers, loaded serially over a valid/ready handshake.
- Answers rank queries: how many stored numbers are strictly less than the query, and how many are equal to it.
- Scans sequentially, one element per cycle, so it has no sorting network; used by AR object-ordering logic after the value set has been gathered.

---
 rtl/value_rank.sv | 163 ++++++++++++++++
 tb/tb_value_rank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/value_rank.sv
// ============================================================================
// value_rank : serially loaded buffer that answers value -> rank queries by a
//              one-element-per-cycle scan (count strictly-less and equal).
// Revision   : 1.0
// ============================================================================
`default_nettype none

module value_rank #(
  parameter int MAX_NUM_SIZE = 32,
  parameter int NUM_OF_NUMS  = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             clear_in,
  input  logic                             load_valid_in,
  input  logic [MAX_NUM_SIZE-1:0]          load_data_in,
  output logic                             load_ready_out,
  input  logic                             query_valid_in,
  input  logic [MAX_NUM_SIZE-1:0]          query_data_in,
  output logic                             query_ready_out,
  output logic [$clog2(NUM_OF_NUMS):0]     rank_out,
  output logic [$clog2(NUM_OF_NUMS):0]     equal_count_out,
  output logic                             found_out,
  output logic                             valid_out
);

  localparam int IW = $clog2(NUM_OF_NUMS);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OF_NUMS - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [MAX_NUM_SIZE-1:0] query_q, query_d;
  logic [CW-1:0]           lt_q, lt_d;
  logic [CW-1:0]           eq_q, eq_d;
  logic [CW-1:0]           rank_q, rank_d;
  logic [CW-1:0]           eqc_q, eqc_d;
  logic                    found_q, found_d;
  logic                    valid_q, valid_d;
  logic                    mem_we;
  logic [MAX_NUM_SIZE-1:0] mem_q [NUM_OF_NUMS];

  logic                    w_lt_hit;
  logic                    w_eq_hit;
  logic [CW-1:0]           w_lt_sum;
  logic [CW-1:0]           w_eq_sum;

  assign w_lt_hit = (mem_q[idx_q] < query_q);
  assign w_eq_hit = (mem_q[idx_q] == query_q);
  // Counters are one bit wider than the index so a full count of N fits.
  assign w_lt_sum = lt_q + CW'(w_lt_hit);
  assign w_eq_sum = eq_q + CW'(w_eq_hit);

  assign load_ready_out  = (state_q == ST_LOAD);
  assign query_ready_out = (state_q == ST_READY);
  assign rank_out        = rank_q;
  assign equal_count_out = eqc_q;
  assign found_out       = found_q;
  assign valid_out       = valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    query_d = query_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    rank_d  = rank_q;
    eqc_d   = eqc_q;
    found_d = found_q;
    valid_d = 1'b0;
    mem_we  = 1'b0;
    if (clear_in) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      rank_d  = '0;
      eqc_d   = '0;
      found_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_valid_in) begin
            mem_we = 1'b1;
            if (cnt_q == LAST_IDX) begin
              cnt_d   = '0;
              state_d = ST_READY;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (query_valid_in) begin
            query_d = query_data_in;
            lt_d    = '0;
            eq_d    = '0;
            idx_d   = '0;
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          lt_d  = w_lt_sum;
          eq_d  = w_eq_sum;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            rank_d  = w_lt_sum;
            eqc_d   = w_eq_sum;
            found_d = (w_eq_sum != '0);
            valid_d = 1'b1;
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_READY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      query_q <= '0;
      lt_q    <= '0;
      eq_q    <= '0;
      rank_q  <= '0;
      eqc_q   <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      query_q <= query_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      rank_q  <= rank_d;
      eqc_q   <= eqc_d;
      found_q <= found_d;
      valid_q <= valid_d;
    end
  end

  // Buffer contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      mem_q[cnt_q] <= load_data_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_value_rank.sv
// ============================================================================
// tb_value_rank : directed plus randomized checks of value_rank against a
//                 counting reference model.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_value_rank;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = $clog2(N) + 1;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          clear_in = 1'b0;
  logic          load_valid_in = 1'b0;
  logic [W-1:0]  load_data_in = '0;
  logic          load_ready_out;
  logic          query_valid_in = 1'b0;
  logic [W-1:0]  query_data_in = '0;
  logic          query_ready_out;
  logic [CW-1:0] rank_out;
  logic [CW-1:0] equal_count_out;
  logic          found_out;
  logic          valid_out;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model [N];

  always #5 clk_in = ~clk_in;

  value_rank #(.MAX_NUM_SIZE(W), .NUM_OF_NUMS(N)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .clear_in        (clear_in),
    .load_valid_in   (load_valid_in),
    .load_data_in    (load_data_in),
    .load_ready_out  (load_ready_out),
    .query_valid_in  (query_valid_in),
    .query_data_in   (query_data_in),
    .query_ready_out (query_ready_out),
    .rank_out        (rank_out),
    .equal_count_out (equal_count_out),
    .found_out       (found_out),
    .valid_out       (valid_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int ref_less(input logic [W-1:0] q);
    int n = 0;
    for (int i = 0; i < N; i++) if (model[i] < q) n++;
    return n;
  endfunction

  function automatic int ref_equal(input logic [W-1:0] q);
    int n = 0;
    for (int i = 0; i < N; i++) if (model[i] == q) n++;
    return n;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rank"}, 64'(rank_out), 64'd0);
    check({tag, "_equal"}, 64'(equal_count_out), 64'd0);
    check({tag, "_found"}, 64'(found_out), 64'd0);
    check({tag, "_valid"}, 64'(valid_out), 64'd0);
    check({tag, "_load_ready"}, 64'(load_ready_out), 64'd1);
    check({tag, "_query_ready"}, 64'(query_ready_out), 64'd0);
  endtask

  task automatic load4(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    logic [W-1:0] v [N];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < N; i++) begin
      check("load_ready_before", 64'(load_ready_out), 64'd1);
      load_valid_in = 1'b1;
      load_data_in  = v[i];
      model[i]      = v[i];
      tick();
    end
    load_valid_in = 1'b0;
    load_data_in  = $urandom;
    check("load_ready_full", 64'(load_ready_out), 64'd0);
    check("query_ready_full", 64'(query_ready_out), 64'd1);
  endtask

  task automatic query(input logic [W-1:0] q);
    int wait_c = 0;
    int lat = 0;
    int exp_lt = ref_less(q);
    int exp_eq = ref_equal(q);
    while (!query_ready_out && wait_c < 20) begin
      tick();
      wait_c++;
    end
    check("query_ready_wait", 64'(query_ready_out), 64'd1);
    query_valid_in = 1'b1;
    query_data_in  = q;
    tick();
    query_valid_in = 1'b0;
    query_data_in  = $urandom;
    check("scan_ready_low", 64'(query_ready_out), 64'd0);
    do begin
      tick();
      lat++;
    end while (!valid_out && lat < N + 4);
    check("latency", 64'(lat), 64'(N));
    check("rank", 64'(rank_out), 64'(exp_lt));
    check("equal", 64'(equal_count_out), 64'(exp_eq));
    check("found", 64'(found_out), 64'(exp_eq != 0));
    tick();
    check("valid_one_cycle", 64'(valid_out), 64'd0);
    check("ready_after_done", 64'(query_ready_out), 64'd1);
    check("rank_hold", 64'(rank_out), 64'(exp_lt));
  endtask

  task automatic abort_scan(input bit use_rst);
    int pulses = 0;
    int wait_c = 0;
    while (!query_ready_out && wait_c < 20) begin
      tick();
      wait_c++;
    end
    check("abort_ready_wait", 64'(query_ready_out), 64'd1);
    query_valid_in = 1'b1;
    query_data_in  = $urandom;
    tick();
    query_valid_in = 1'b0;
    tick();
    if (use_rst) rst_in = 1'b1;
    else clear_in = 1'b1;
    tick();
    rst_in   = 1'b0;
    clear_in = 1'b0;
    check_idle_outputs(use_rst ? "abort_rst" : "abort_clr");
    for (int i = 0; i < N + 3; i++) begin
      if (valid_out) pulses++;
      tick();
    end
    check("abort_no_valid", 64'(pulses), 64'd0);
  endtask

  initial begin
    int pulses;
    logic [W-1:0] q;

    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    check_idle_outputs("reset");

    // Queries offered while still loading must be ignored.
    pulses = 0;
    query_valid_in = 1'b1;
    query_data_in  = 32'd5;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid_out) pulses++;
    end
    query_valid_in = 1'b0;
    check("query_in_load_no_valid", 64'(pulses), 64'd0);
    check("query_in_load_ready", 64'(query_ready_out), 64'd0);

    load4(32'd7, 32'd3, 32'd9, 32'd3);
    query(32'd5);
    query(32'd3);
    query(32'd10);
    query(32'd9);

    // Extra load while full must not touch the buffer.
    load_valid_in = 1'b1;
    load_data_in  = 32'd1;
    for (int i = 0; i < 3; i++) tick();
    check("full_load_ready", 64'(load_ready_out), 64'd0);
    query(32'd2);
    load_valid_in = 1'b0;
    query(32'd1);

    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check_idle_outputs("clear_ready");
    load4(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    query(32'hFFFF_FFFF);
    query(32'd0);

    abort_scan(1'b1);
    load4(32'd1, 32'd2, 32'd3, 32'd4);
    query(32'd4);

    abort_scan(1'b0);
    load4(32'd10, 32'd20, 32'd30, 32'd40);
    query(32'd25);
    query(32'd40);

    for (int r = 0; r < 4; r++) begin
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      if (r[0]) load4($urandom, $urandom, $urandom, $urandom);
      else load4($urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 5), $urandom_range(0, 5));
      for (int k = 0; k < 6; k++) begin
        case ($urandom_range(0, 2))
          0:       q = model[$urandom_range(0, N - 1)];
          1:       q = $urandom_range(0, 6);
          default: q = $urandom;
        endcase
        query(q);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
